// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-domain pointers, flags and occupancy for an asynchronous FIFO
module fifo_read_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ALMOST_EMPTY_THRESH = 1
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  rd_valid,
  output logic                  underflow
);
  localparam int pw = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] ae_thresh = pw'(ALMOST_EMPTY_THRESH);
  logic [SYNC_STAGES-1:0][ADDR_WIDTH:0] sync_q;
  logic [ADDR_WIDTH:0] wr_bin_sync, rd_ptr_bin, rd_bin_next, diff;
  logic rd_fire;
  // shift the raw gray write pointer through the synchronizer chain
  always_ff @(posedge rd_clk or posedge rd_rst)
    if (rd_rst) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], wr_ptr_gray};
  // gray to binary: each binary bit is the xor of its gray bit and all above it
  always_comb begin
    wr_bin_sync = '0;
    for (int i = 0; i < pw; i++) wr_bin_sync[i] = ^(sync_q[SYNC_STAGES-1] >> i);
  end
  assign rd_fire     = rd_en & ~empty;
  assign rd_bin_next = rd_ptr_bin + {{ADDR_WIDTH{1'b0}}, rd_fire};
  assign diff        = wr_bin_sync - rd_bin_next;
  assign rd_addr     = rd_ptr_bin[ADDR_WIDTH-1:0];
  // advance the read pointer and register flags against the synchronized write pointer
  always_ff @(posedge rd_clk or posedge rd_rst)
    if (rd_rst) begin
      rd_ptr_bin   <= '0;
      rd_ptr_gray  <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      rd_valid     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      rd_ptr_bin   <= rd_bin_next;
      rd_ptr_gray  <= rd_bin_next ^ (rd_bin_next >> 1);
      empty        <= rd_bin_next == wr_bin_sync;
      almost_empty <= diff <= ae_thresh;
      rd_count     <= diff;
      rd_valid     <= rd_fire;
      underflow    <= rd_en & empty;
    end
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: scoreboard bench for the FIFO read-domain controller
module tb_fifo_read_ctrl;
  logic rd_clk = 1'b0, rd_rst = 1'b1, rd_en = 1'b1;
  logic [4:0] wr_ptr_gray = '0;
  logic [4:0] rd_ptr_gray, rd_count;
  logic [3:0] rd_addr;
  logic empty, almost_empty, rd_valid, underflow;
  int checks = 0, failures = 0;
  int m_rd, m_s0, m_s1, m_cnt, wcnt, n, nv;
  bit m_empty, m_ae, m_valid, m_uf;
  int sb[$];
  logic [3:0] pre_addr;
  logic [4:0] prev_gray;

  fifo_read_ctrl #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .ALMOST_EMPTY_THRESH(1)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_en(rd_en), .wr_ptr_gray(wr_ptr_gray),
    .rd_ptr_gray(rd_ptr_gray), .rd_addr(rd_addr), .empty(empty),
    .almost_empty(almost_empty), .rd_count(rd_count), .rd_valid(rd_valid),
    .underflow(underflow)
  );

  always #5 rd_clk = ~rd_clk;

  function automatic logic [4:0] gray(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset;
    m_rd = 0; m_s0 = 0; m_s1 = 0; m_cnt = 0;
    m_empty = 1; m_ae = 1; m_valid = 0; m_uf = 0;
    sb.delete();
  endtask

  task automatic check_outputs;
    chk("empty", empty, m_empty);
    chk("almost_empty", almost_empty, m_ae);
    chk("rd_count", rd_count, m_cnt);
    chk("rd_valid", rd_valid, m_valid);
    chk("underflow", underflow, m_uf);
    chk("rd_ptr_gray", rd_ptr_gray, gray(m_rd));
    chk("rd_addr", rd_addr, m_rd % 16);
  endtask

  task automatic cycle(input bit en);
    int ws;
    bit fire;
    rd_en = en;
    wr_ptr_gray = gray(wcnt);
    pre_addr = rd_addr;
    @(posedge rd_clk);
    if (rd_rst) m_reset;
    else begin
      ws = m_s1;
      fire = en && !m_empty;
      if (fire) sb.push_back(m_rd % 16);
      m_uf = en && m_empty;
      m_valid = fire;
      m_rd = (m_rd + int'(fire)) % 32;
      m_cnt = (ws - m_rd) & 31;
      m_empty = (m_rd == ws);
      m_ae = m_cnt <= 1;
      m_s1 = m_s0;
      m_s0 = wcnt % 32;
    end
    #1;
    check_outputs;
    if (rd_valid) begin
      if (sb.size() == 0) chk("sb_pop", 0, 1);
      else chk("rd_addr_at_accept", pre_addr, sb.pop_front());
    end
    if (!rd_rst) chk("gray_one_bit", int'($countones(rd_ptr_gray ^ prev_gray) <= 1), 1);
    prev_gray = rd_ptr_gray;
  endtask

  initial begin
    m_reset;
    wcnt = 0;
    prev_gray = '0;
    repeat (2) cycle(1);
    chk("rst_empty", empty, 1);
    chk("rst_gray", rd_ptr_gray, 0);
    chk("rst_count", rd_count, 0);
    chk("rst_underflow", underflow, 0);
    rd_rst = 1'b0;
    wcnt = 1;
    n = 0;
    while (empty && n < 10) begin
      cycle(0);
      n++;
    end
    chk("visibility_latency", n, 3);
    chk("single_count", rd_count, 1);
    chk("single_ae", almost_empty, 1);
    cycle(1);
    chk("single_valid", rd_valid, 1);
    chk("single_empty", empty, 1);
    chk("single_gray", rd_ptr_gray, 1);
    chk("single_count0", rd_count, 0);
    wcnt = 17;
    repeat (4) cycle(0);
    chk("full_count", rd_count, 16);
    chk("full_ae", almost_empty, 0);
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1);
      if (rd_valid) nv++;
      if (i == 14) chk("pre_last_empty", empty, 0);
    end
    chk("drain_valids", nv, 16);
    chk("drain_empty", empty, 1);
    cycle(0);
    repeat (2) begin
      cycle(1);
      chk("uf_pulse", underflow, 1);
      chk("uf_no_valid", rd_valid, 0);
      chk("uf_ptr_hold", rd_ptr_gray, gray(17));
    end
    cycle(0);
    chk("uf_clear", underflow, 0);
    for (int i = 0; i < 40; i++) begin
      wcnt++;
      repeat (3) cycle(0);
      cycle(1);
    end
    chk("wrap_ptr", rd_ptr_gray, gray(57));
    wcnt += 7;
    repeat (4) cycle(0);
    repeat (2) cycle(1);
    chk("burst_count", rd_count, 5);
    #3;
    rd_rst = 1'b1;
    #1;
    chk("async_empty", empty, 1);
    chk("async_ae", almost_empty, 1);
    chk("async_count", rd_count, 0);
    chk("async_valid", rd_valid, 0);
    chk("async_underflow", underflow, 0);
    chk("async_gray", rd_ptr_gray, 0);
    chk("async_addr", rd_addr, 0);
    m_reset;
    wcnt = 0;
    prev_gray = '0;
    repeat (2) cycle(1);
    rd_rst = 1'b0;
    wcnt = 3;
    repeat (4) cycle(0);
    chk("resync_count", rd_count, 3);
    chk("resync_empty", empty, 0);
    chk("sb_leftover", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
